// File: rtl/irq_ctrl_n_if.sv
// rtl/irq_ctrl_n_if.sv - core-facing signal bundle of the irq_ctrl_n interrupt controller
//
// Purpose: groups the decoded command port, the interrupt lines and the status
// outputs that travel between the core (master) and irq_ctrl_n (slave).
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   inirr      in   NSRC  external interrupt lines; bits [NTIMER:0] are ignored
//   cmd_valid  in   1     command strobe, one command per cycle
//   cmd_op     in   4     opcode
//   cmd_a      in   32    operand (rs1)
//   cmd_b      in   32    operand (imm/rs2)
//   cmd_ch     in   2     timer channel index
//   savepc     in   1     latch pc into pc_c
//   pc         in   32    current core PC
//   flag       out  1     interrupt active
//   irq_id     out  5     index of the active source
//   pc_irq     out  32    handler vector
//   pc_c       out  32    saved return PC
//   outirr     out  NSRC  one-cycle clear acknowledge, per bit
//   rd         out  32    registered read data

interface irq_ctrl_n_if #(
   parameter int NSRC = 32
);
   logic [NSRC-1:0] inirr;
   logic            cmd_valid;
   logic [3:0]      cmd_op;
   logic [31:0]     cmd_a;
   logic [31:0]     cmd_b;
   logic [1:0]      cmd_ch;
   logic            savepc;
   logic [31:0]     pc;
   logic            flag;
   logic [4:0]      irq_id;
   logic [31:0]     pc_irq;
   logic [31:0]     pc_c;
   logic [NSRC-1:0] outirr;
   logic [31:0]     rd;

   modport master (
      output inirr, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_ch, savepc, pc,
      input  flag, irq_id, pc_irq, pc_c, outirr, rd
   );

   modport slave (
      input  inirr, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_ch, savepc, pc,
      output flag, irq_id, pc_irq, pc_c, outirr, rd
   );
endinterface

// File: rtl/irq_ctrl_n.sv
// rtl/irq_ctrl_n.sv - parametrised interrupt controller with prescaled timer channels
//
// Purpose: latches NSRC interrupt sources into a maskable pending register and
// raises flag with the lowest-index pending & mask source. Source 0 is the
// software ebreak, sources 1..NTIMER are internal timer channels, the rest come
// from bus.inirr (edge or level per mode bit). The core drives the block via a
// decoded command port.
//
// Parameters:
//   NSRC    number of interrupt sources (4..32)
//   NTIMER  number of timer channels (1..4), NTIMER+1 < NSRC
//   TW      timer prescaler / compare width (<= 32)
//
// Ports:
//   i_clk   in     clock, rising edge
//   i_rst   in     synchronous active-high reset
//   bus     slave  irq_ctrl_n_if bundle (commands, lines, status outputs)

module irq_ctrl_n #(
   parameter int NSRC   = 32,
   parameter int NTIMER = 2,
   parameter int TW     = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   irq_ctrl_n_if.slave     bus
);

   localparam logic [3:0] OP_ADDPCIRQ = 4'd0;
   localparam logic [3:0] OP_EBREAK   = 4'd1;
   localparam logic [3:0] OP_SETMASK  = 4'd2;
   localparam logic [3:0] OP_SETMODE  = 4'd3;
   localparam logic [3:0] OP_TIMONE   = 4'd4;
   localparam logic [3:0] OP_TIMPER   = 4'd5;
   localparam logic [3:0] OP_TIMSTOP  = 4'd6;
   localparam logic [3:0] OP_CLRIRQ   = 4'd7;
   localparam logic [3:0] OP_IRQSTATE = 4'd8;
   localparam logic [3:0] OP_RETIRQ   = 4'd9;
   localparam logic [3:0] OP_RDMASK   = 4'd10;

   // Positions fed by bus.inirr; ebreak and timer positions are forced off.
   localparam logic [NSRC-1:0] L_EXT_BITS = {NSRC{1'b1}} << (NTIMER + 1);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   // ---------------------------------------------------------------- decode
   logic w_op_addpc;
   logic w_op_ebreak;
   logic w_op_setmask;
   logic w_op_setmode;
   logic w_op_timone;
   logic w_op_timper;
   logic w_op_timstop;
   logic w_op_clr;
   logic w_op_state;
   logic w_op_ret;
   logic w_op_rdmask;

   assign w_op_addpc   = bus.cmd_valid && (bus.cmd_op == OP_ADDPCIRQ);
   assign w_op_ebreak  = bus.cmd_valid && (bus.cmd_op == OP_EBREAK);
   assign w_op_setmask = bus.cmd_valid && (bus.cmd_op == OP_SETMASK);
   assign w_op_setmode = bus.cmd_valid && (bus.cmd_op == OP_SETMODE);
   assign w_op_timone  = bus.cmd_valid && (bus.cmd_op == OP_TIMONE);
   assign w_op_timper  = bus.cmd_valid && (bus.cmd_op == OP_TIMPER);
   assign w_op_timstop = bus.cmd_valid && (bus.cmd_op == OP_TIMSTOP);
   assign w_op_clr     = bus.cmd_valid && (bus.cmd_op == OP_CLRIRQ);
   assign w_op_state   = bus.cmd_valid && (bus.cmd_op == OP_IRQSTATE);
   assign w_op_ret     = bus.cmd_valid && (bus.cmd_op == OP_RETIRQ);
   assign w_op_rdmask  = bus.cmd_valid && (bus.cmd_op == OP_RDMASK);

   logic [31:0] w_ab;
   assign w_ab = bus.cmd_a | bus.cmd_b;

   // ---------------------------------------------------------------- state
   logic [NSRC-1:0] r_samp;      // inirr sampled this edge
   logic [NSRC-1:0] r_prev;      // previous sample, for 0->1 detection
   logic            r_ebreak;    // registered one-cycle ebreak pulse
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_mode;      // 1 = edge, 0 = level
   logic [NSRC-1:0] r_outirr;
   logic [31:0]     r_rd;
   logic [31:0]     r_pc_irq;
   logic [31:0]     r_pc_c;
   state_t          r_state;
   logic            r_flag;
   logic [4:0]      r_irq_id;

   logic [NTIMER-1:0] w_fire;

   // ---------------------------------------------------------------- timers
   // A channel only reacts to its own index, so cmd_ch >= NTIMER falls
   // through every channel and is a no-op.
   for (genvar g = 0; g < NTIMER; g++) begin : g_tmr
      logic          r_run;
      logic          r_per;
      logic          r_fire;
      logic [TW-1:0] r_presc;
      logic [TW-1:0] r_max;
      logic [TW-1:0] r_pcnt;
      logic [TW-1:0] r_cnt;
      logic          w_sel;
      logic [TW-1:0] w_last;
      logic          w_tick;

      assign w_sel  = (bus.cmd_ch == 2'(g));
      // presc == 0 behaves like presc == 1: tick on every cycle.
      assign w_last = (r_presc == '0) ? '0 : (r_presc - 1'b1);
      assign w_tick = (r_pcnt == w_last);
      assign w_fire[g] = r_fire;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_run   <= 1'b0;
            r_per   <= 1'b0;
            r_fire  <= 1'b0;
            r_presc <= '0;
            r_max   <= '0;
            r_pcnt  <= '0;
            r_cnt   <= '0;
         end else begin
            r_fire <= 1'b0;
            if (w_sel && (w_op_timone || w_op_timper)) begin
               // (Re)start: both counters restart from 0 even if running.
               r_run   <= 1'b1;
               r_per   <= w_op_timper;
               r_presc <= bus.cmd_a[TW-1:0];
               r_max   <= bus.cmd_b[TW-1:0];
               r_pcnt  <= '0;
               r_cnt   <= '0;
            end else if (w_sel && w_op_timstop) begin
               r_run  <= 1'b0;
               r_pcnt <= '0;
               r_cnt  <= '0;
            end else if (r_run) begin
               if (w_tick) begin
                  r_pcnt <= '0;
                  if (r_cnt == r_max) begin
                     r_cnt  <= '0;
                     r_fire <= 1'b1;
                     if (!r_per) begin
                        r_run <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_pcnt <= r_pcnt + 1'b1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- sources
   logic [NSRC-1:0] w_src_int;
   logic [NSRC-1:0] w_src_ext;
   logic [NSRC-1:0] w_set;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_eff;
   logic [4:0]      w_lowest;

   always_comb begin
      w_src_int           = '0;
      w_src_int[0]        = r_ebreak;
      w_src_int[NTIMER:1] = w_fire;
   end

   // Edge mode looks for a rising sample, level mode re-asserts every cycle.
   assign w_src_ext = ((r_mode & r_samp & ~r_prev) | (~r_mode & r_samp)) & L_EXT_BITS;
   assign w_set     = w_src_int | w_src_ext;
   assign w_clr     = w_op_clr ? w_ab[NSRC-1:0] : '0;
   assign w_eff     = r_pending & r_mask;

   function automatic logic [4:0] f_lowest(input logic [NSRC-1:0] v);
      logic [4:0] id;
      id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            id = 5'(i);
         end
      end
      return id;
   endfunction

   assign w_lowest = f_lowest(w_eff);

   // ---------------------------------------------------------------- registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_samp    <= '0;
         r_prev    <= '0;
         r_ebreak  <= 1'b0;
         r_pending <= '0;
         r_mask    <= '0;
         r_mode    <= '0;
         r_outirr  <= '0;
         r_rd      <= '0;
         r_pc_irq  <= '0;
         r_pc_c    <= '0;
      end else begin
         r_samp   <= bus.inirr;
         r_prev   <= r_samp;
         r_ebreak <= w_op_ebreak;
         // Set has priority over a simultaneous clear of the same bit.
         r_pending <= (r_pending & ~w_clr) | w_set;
         r_outirr  <= w_clr & r_pending;
         if (w_op_setmask) begin
            r_mask <= bus.cmd_a[NSRC-1:0];
         end
         if (w_op_setmode) begin
            r_mode <= bus.cmd_a[NSRC-1:0];
         end
         if (w_op_addpc) begin
            r_pc_irq <= w_ab;
         end
         // rd only changes on a read opcode.
         if (w_op_state) begin
            r_rd <= 32'(r_pending);
         end else if (w_op_rdmask) begin
            r_rd <= 32'(r_mask);
         end
         if (bus.savepc) begin
            r_pc_c <= bus.pc;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   // Once ACTIVE, only RETIRQ can leave; a later mask change does not drop flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_flag   <= 1'b0;
         r_irq_id <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_eff != '0) begin
                  r_state  <= S_ACTIVE;
                  r_flag   <= 1'b1;
                  r_irq_id <= w_lowest;
               end
            end
            S_ACTIVE: begin
               if (w_op_ret) begin
                  if (w_eff == '0) begin
                     r_state  <= S_IDLE;
                     r_flag   <= 1'b0;
                     r_irq_id <= '0;
                  end else begin
                     r_irq_id <= w_lowest;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_flag   <= 1'b0;
               r_irq_id <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.flag   = r_flag;
   assign bus.irq_id = r_irq_id;
   assign bus.pc_irq = r_pc_irq;
   assign bus.pc_c   = r_pc_c;
   assign bus.outirr = r_outirr;
   assign bus.rd     = r_rd;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb/tb_irq_ctrl_n.sv - directed self-checking bench for irq_ctrl_n
module tb_irq_ctrl_n;

   localparam logic [3:0] OP_ADDPCIRQ = 4'd0;
   localparam logic [3:0] OP_EBREAK   = 4'd1;
   localparam logic [3:0] OP_SETMASK  = 4'd2;
   localparam logic [3:0] OP_SETMODE  = 4'd3;
   localparam logic [3:0] OP_TIMONE   = 4'd4;
   localparam logic [3:0] OP_TIMPER   = 4'd5;
   localparam logic [3:0] OP_TIMSTOP  = 4'd6;
   localparam logic [3:0] OP_CLRIRQ   = 4'd7;
   localparam logic [3:0] OP_IRQSTATE = 4'd8;
   localparam logic [3:0] OP_RETIRQ   = 4'd9;
   localparam logic [3:0] OP_RDMASK   = 4'd10;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   irq_ctrl_n_if #(.NSRC(32)) bus ();

   irq_ctrl_n #(.NSRC(32), .NTIMER(2), .TW(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] ch);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_ch    = ch;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'hF;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_ch    = '0;
   endtask

   task automatic wait_flag(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.flag === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic count_flag(input int len, output int n);
      n = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (bus.flag !== 1'b0) n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %0b want 0", bus.flag); end
      checks++; if (bus.irq_id !== 5'd0) begin failures++; $display("FAIL reset_irq_id: got %0d want 0", bus.irq_id); end
      checks++; if (bus.pc_irq !== 32'd0) begin failures++; $display("FAIL reset_pc_irq: got %h want 0", bus.pc_irq); end
      checks++; if (bus.pc_c !== 32'd0) begin failures++; $display("FAIL reset_pc_c: got %h want 0", bus.pc_c); end
      checks++; if (bus.outirr !== 32'd0) begin failures++; $display("FAIL reset_outirr: got %h want 0", bus.outirr); end
      checks++; if (bus.rd !== 32'd0) begin failures++; $display("FAIL reset_rd: got %h want 0", bus.rd); end
   endtask

   task automatic test_edge();
      cmd(OP_SETMASK, 32'hFFFF_FFF8, 0, 0);
      cmd(OP_SETMODE, 32'hFFFF_FFF8, 0, 0);
      bus.inirr = 32'h20;
      tick(1);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL edge_flag_n: got %0b want 0", bus.flag); end
      tick(1);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL edge_flag_n1: got %0b want 0", bus.flag); end
      tick(1);
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL edge_flag_n2: got %0b want 1", bus.flag); end
      checks++; if (bus.irq_id !== 5'd5) begin failures++; $display("FAIL edge_irq_id: got %0d want 5", bus.irq_id); end
      bus.inirr = '0;
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h20) begin failures++; $display("FAIL edge_pending: got %h want 20", bus.rd); end
      cmd(OP_CLRIRQ, 32'h20, 0, 0);
      checks++; if (bus.outirr !== 32'h20) begin failures++; $display("FAIL edge_outirr: got %h want 20", bus.outirr); end
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.outirr !== 32'h0) begin failures++; $display("FAIL edge_outirr_1cyc: got %h want 0", bus.outirr); end
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL edge_ret_flag: got %0b want 0", bus.flag); end
      checks++; if (bus.irq_id !== 5'd0) begin failures++; $display("FAIL edge_ret_id: got %0d want 0", bus.irq_id); end
   endtask

   task automatic test_priority();
      bus.inirr = 32'h210;
      tick(3);
      bus.inirr = '0;
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL prio_flag: got %0b want 1", bus.flag); end
      checks++; if (bus.irq_id !== 5'd4) begin failures++; $display("FAIL prio_id: got %0d want 4", bus.irq_id); end
      cmd(OP_CLRIRQ, 32'h10, 0, 0);
      checks++; if (bus.outirr !== 32'h10) begin failures++; $display("FAIL prio_outirr: got %h want 10", bus.outirr); end
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL prio_ret_flag: got %0b want 1", bus.flag); end
      checks++; if (bus.irq_id !== 5'd9) begin failures++; $display("FAIL prio_ret_id: got %0d want 9", bus.irq_id); end
      checks++; if (bus.outirr !== 32'h0) begin failures++; $display("FAIL prio_outirr_1cyc: got %h want 0", bus.outirr); end
      cmd(OP_CLRIRQ, 0, 32'h200, 0);
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL prio_final_flag: got %0b want 0", bus.flag); end
   endtask

   task automatic test_level();
      cmd(OP_SETMODE, 32'hFFFF_FF78, 0, 0);
      bus.inirr = 32'h80;
      tick(3);
      checks++; if (bus.irq_id !== 5'd7 || bus.flag !== 1'b1) begin failures++; $display("FAIL level_active: got flag=%0b id=%0d want flag=1 id=7", bus.flag, bus.irq_id); end
      cmd(OP_CLRIRQ, 32'h80, 0, 0);
      checks++; if (bus.outirr !== 32'h80) begin failures++; $display("FAIL level_outirr: got %h want 80", bus.outirr); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h80) begin failures++; $display("FAIL level_reset_wins: got %h want 80", bus.rd); end
      bus.inirr = '0;
      tick(2);
      cmd(OP_CLRIRQ, 32'h80, 0, 0);
      checks++; if (bus.outirr !== 32'h80) begin failures++; $display("FAIL level_outirr2: got %h want 80", bus.outirr); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h0) begin failures++; $display("FAIL level_cleared: got %h want 0", bus.rd); end
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL level_ret_flag: got %0b want 0", bus.flag); end
      cmd(OP_SETMODE, 32'hFFFF_FFF8, 0, 0);
   endtask

   task automatic test_ebreak();
      cmd(OP_SETMASK, 32'h1, 0, 0);
      cmd(OP_EBREAK, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL ebreak_flag_n: got %0b want 0", bus.flag); end
      tick(1);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL ebreak_flag_n1: got %0b want 0", bus.flag); end
      tick(1);
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL ebreak_flag_n2: got %0b want 1", bus.flag); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h1) begin failures++; $display("FAIL ebreak_pending: got %h want 1", bus.rd); end
      cmd(OP_CLRIRQ, 32'h1, 0, 0);
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL ebreak_ret: got %0b want 0", bus.flag); end
   endtask

   task automatic test_timer();
      int s;
      int at1;
      int at2;
      int n;
      cmd(OP_SETMASK, 32'h4, 0, 0);
      cmd(OP_TIMPER, 32'd4, 32'd2, 2'd1);
      s = cyc;
      // fire at start+12, pending +13, flag +14
      wait_flag(40, at1);
      checks++; if (at1 - s !== 14) begin failures++; $display("FAIL tim_per_first: got %0d want 14 cycles", at1 - s); end
      cmd(OP_CLRIRQ, 32'h4, 0, 0);
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL tim_per_ret: got %0b want 0", bus.flag); end
      wait_flag(40, at2);
      checks++; if (at1 < 0 || at2 - at1 !== 12) begin failures++; $display("FAIL tim_per_period: got %0d want 12", at2 - at1); end
      cmd(OP_CLRIRQ, 32'h4, 0, 0);
      cmd(OP_RETIRQ, 0, 0, 0);
      cmd(OP_TIMSTOP, 0, 0, 2'd1);
      count_flag(40, n);
      checks++; if (n !== 0) begin failures++; $display("FAIL tim_stop: got %0d flag cycles want 0", n); end
      cmd(OP_SETMASK, 32'hE, 0, 0);
      cmd(OP_TIMONE, 0, 0, 2'd2);
      cmd(OP_TIMPER, 0, 0, 2'd3);
      count_flag(10, n);
      checks++; if (n !== 0) begin failures++; $display("FAIL tim_bad_ch: got %0d flag cycles want 0", n); end
      cmd(OP_SETMASK, 32'h2, 0, 0);
      cmd(OP_TIMONE, 32'd0, 32'd0, 2'd0);
      s = cyc;
      wait_flag(10, at1);
      checks++; if (at1 - s !== 3) begin failures++; $display("FAIL tim_one_latency: got %0d want 3 cycles", at1 - s); end
      cmd(OP_CLRIRQ, 32'h2, 0, 0);
      cmd(OP_RETIRQ, 0, 0, 0);
      count_flag(20, n);
      checks++; if (n !== 0) begin failures++; $display("FAIL tim_one_once: got %0d flag cycles want 0", n); end
   endtask

   task automatic test_misc();
      int n;
      cmd(OP_ADDPCIRQ, 32'h100, 32'h4, 0);
      checks++; if (bus.pc_irq !== 32'h104) begin failures++; $display("FAIL pc_irq: got %h want 104", bus.pc_irq); end
      bus.savepc = 1'b1;
      bus.pc     = 32'h2C;
      tick(1);
      bus.savepc = 1'b0;
      bus.pc     = 32'h99;
      checks++; if (bus.pc_c !== 32'h2C) begin failures++; $display("FAIL pc_c: got %h want 2c", bus.pc_c); end
      tick(1);
      checks++; if (bus.pc_c !== 32'h2C) begin failures++; $display("FAIL pc_c_hold: got %h want 2c", bus.pc_c); end
      cmd(OP_SETMASK, 32'hFFFF_FFD8, 0, 0);
      cmd(OP_RDMASK, 0, 0, 0);
      checks++; if (bus.rd !== 32'hFFFF_FFD8) begin failures++; $display("FAIL rdmask: got %h want ffffffd8", bus.rd); end
      bus.inirr = 32'h20;
      tick(1);
      bus.inirr = '0;
      count_flag(4, n);
      checks++; if (n !== 0) begin failures++; $display("FAIL masked_flag: got %0d flag cycles want 0", n); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h20) begin failures++; $display("FAIL masked_pending: got %h want 20", bus.rd); end
      cmd(OP_ADDPCIRQ, 0, 0, 0);
      checks++; if (bus.rd !== 32'h20) begin failures++; $display("FAIL rd_hold: got %h want 20", bus.rd); end
      cmd(OP_SETMASK, 32'hFFFF_FFF8, 0, 0);
      tick(1);
      checks++; if (bus.flag !== 1'b1 || bus.irq_id !== 5'd5) begin failures++; $display("FAIL unmask_flag: got flag=%0b id=%0d want flag=1 id=5", bus.flag, bus.irq_id); end
      cmd(OP_SETMASK, 0, 0, 0);
      tick(2);
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL mask_clear_active: got %0b want 1", bus.flag); end
      cmd(OP_RETIRQ, 0, 0, 0);
      checks++; if (bus.flag !== 1'b0) begin failures++; $display("FAIL mask_clear_ret: got %0b want 0", bus.flag); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'h20) begin failures++; $display("FAIL mask_keeps_pending: got %h want 20", bus.rd); end
      cmd(OP_CLRIRQ, 32'h20, 0, 0);
   endtask

   task automatic test_reset_mid();
      int n;
      cmd(OP_SETMASK, 32'hFFFF_FFFF, 0, 0);
      cmd(OP_TIMPER, 32'd2, 32'd3, 2'd0);
      cmd(OP_ADDPCIRQ, 32'h40, 0, 0);
      bus.savepc = 1'b1;
      bus.pc     = 32'h80;
      tick(1);
      bus.savepc = 1'b0;
      cmd(OP_EBREAK, 0, 0, 0);
      tick(2);
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.flag !== 1'b1) begin failures++; $display("FAIL rstmid_pre_flag: got %0b want 1", bus.flag); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++; if (bus.flag !== 1'b0 || bus.irq_id !== 5'd0) begin failures++; $display("FAIL rstmid_flag: got flag=%0b id=%0d want 0 0", bus.flag, bus.irq_id); end
      checks++; if (bus.pc_irq !== 32'd0 || bus.pc_c !== 32'd0) begin failures++; $display("FAIL rstmid_pc: got pc_irq=%h pc_c=%h want 0 0", bus.pc_irq, bus.pc_c); end
      checks++; if (bus.rd !== 32'd0 || bus.outirr !== 32'd0) begin failures++; $display("FAIL rstmid_rd: got rd=%h outirr=%h want 0 0", bus.rd, bus.outirr); end
      cmd(OP_SETMASK, 32'hFFFF_FFFF, 0, 0);
      count_flag(30, n);
      checks++; if (n !== 0) begin failures++; $display("FAIL rstmid_timer_dead: got %0d flag cycles want 0", n); end
      cmd(OP_IRQSTATE, 0, 0, 0);
      checks++; if (bus.rd !== 32'd0) begin failures++; $display("FAIL rstmid_pending: got %h want 0", bus.rd); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.inirr     = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 4'hF;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_ch    = '0;
      bus.savepc    = 1'b0;
      bus.pc        = '0;
      test_reset();
      test_edge();
      test_priority();
      test_level();
      test_ebreak();
      test_timer();
      test_misc();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
